button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debounce_pkg.sv | 20 ++
 rtl/button_debouncer_sync_2ff.sv | 36 +++
 rtl/button_debouncer.sv | 174 +++++++++++++++++
 tb/tb_button_debouncer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
// Shared definitions for the pushbutton debouncer:
//   db_state_e              - debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT - default stable-cycle count (10 ms at 50 MHz)
//   BOUNCE_CNT_W            - width of the optional bounce statistics counter
// -----------------------------------------------------------------------------
package button_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_HI = 2'b00,
    PEND_LO   = 2'b01,
    STABLE_LO = 2'b10,
    PEND_HI   = 2'b11
  } db_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned BOUNCE_CNT_W            = 16;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit. Both flops load
// RESET_VAL on a synchronous active-low reset so the downstream logic sees the
// reset level, not a stale pin value, on the first cycle after reset.
// Ports:
//   clk_i     - system clock
//   reset_n_i - synchronous active-low reset
//   d_i       - asynchronous input
//   q_o       - synchronised output (2 cycles latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ff1_q <= RESET_VAL;
      ff2_q <= RESET_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Debounces a raw pushbutton pin. The pin is synchronised, then a 4-state FSM
// accepts a level change only after it has held for DEBOUNCE_CYCLES cycles.
// A return to the old level while pending aborts the change (one "bounce").
// Optional feature macro: DEBOUNCE_STATS_EN adds a saturating bounce counter.
// Ports:
//   clk           - system clock
//   reset_n       - synchronous active-low reset
//   btn_in        - raw asynchronous button pin
//   btn_out       - debounced level (RESET_LEVEL after reset)
//   press_pulse   - one-cycle strobe on a debounced 1->0 transition
//   release_pulse - one-cycle strobe on a debounced 0->1 transition
//   stats_clr     - (DEBOUNCE_STATS_EN) clear bounce_count on next edge
//   bounce_count  - (DEBOUNCE_STATS_EN) number of aborted changes, saturating
//   dbg_state_o   - current FSM state (db_state_e encoding) for observation
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    btn_in,
  output logic                    btn_out,
  output logic                    press_pulse,
  output logic                    release_pulse,
`ifdef DEBOUNCE_STATS_EN
  input  logic                    stats_clr,
  output logic [BOUNCE_CNT_W-1:0] bounce_count,
`endif
  output logic [1:0]              dbg_state_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Terminal count: reaching it while the new level still holds commits it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam db_state_e RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic s;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_out_q, btn_out_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .d_i       (btn_in),
    .q_o       (s)
  );

  // State register (also holds the registered outputs).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      btn_out_q <= RESET_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_out_q <= btn_out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic. cnt never exceeds CNT_LAST, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = '0;
        end
      end
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = '0;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: the debounced level and strobes move only on a committed
  // PEND -> STABLE transition, so they are registered on that same edge.
  always_comb begin
    btn_out_d = btn_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (state_q == PEND_LO && state_d == STABLE_LO) begin
      btn_out_d = 1'b0;
      press_d   = 1'b1;
    end
    if (state_q == PEND_HI && state_d == STABLE_HI) begin
      btn_out_d = 1'b1;
      release_d = 1'b1;
    end
  end

  assign btn_out       = btn_out_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dbg_state_o   = state_q;

`ifdef DEBOUNCE_STATS_EN
  logic                    abort;
  logic [BOUNCE_CNT_W-1:0] bounce_q, bounce_d;

  // A pending change aborts when the synchronised level returns to the old one.
  assign abort = ((state_q == PEND_LO) &&  s) ||
                 ((state_q == PEND_HI) && !s);

  // Clear wins over a coincident abort; the count sticks at all-ones.
  always_comb begin
    bounce_d = bounce_q;
    if (stats_clr) begin
      bounce_d = '0;
    end else if (abort && (bounce_q != '1)) begin
      bounce_d = bounce_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_d;
    end
  end

  assign bounce_count = bounce_q;
`else
  // Statistics disabled: no counter, no extra ports.
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=8, RESET_LEVEL=1.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so "edge N" below means the Nth rising edge after an input change.
// Statistics checks are compiled in when DEBOUNCE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_button_debouncer;
  import button_debounce_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        btn_in;
  logic        btn_out;
  logic        press_pulse;
  logic        release_pulse;
  logic [1:0]  dbg_state;
`ifdef DEBOUNCE_STATS_EN
  logic        stats_clr;
  logic [15:0] bounce_count;
`endif

  int checks = 0;
  int errors = 0;
  int press_seen = 0;
  int release_seen = 0;
  int both_seen = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (8),
    .RESET_LEVEL     (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_in        (btn_in),
    .btn_out       (btn_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
`ifdef DEBOUNCE_STATS_EN
    .stats_clr     (stats_clr),
    .bounce_count  (bounce_count),
`endif
    .dbg_state_o   (dbg_state)
  );

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse)   press_seen++;
    if (release_pulse) release_seen++;
    if (press_pulse && release_pulse) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a clean level and check the edge-10 / edge-11 / edge-12 behaviour.
  task automatic settle(input logic lvl, input string tag);
    int p0;
    int r0;
    p0 = press_seen;
    r0 = release_seen;
    btn_in = lvl;
    step(10);
    chk({tag, "_e10_out"}, 32'(btn_out), 32'(!lvl));
    step(1);
    chk({tag, "_e11_out"}, 32'(btn_out), 32'(lvl));
    chk({tag, "_e11_press"}, 32'(press_pulse), 32'(!lvl));
    chk({tag, "_e11_release"}, 32'(release_pulse), 32'(lvl));
    step(1);
    chk({tag, "_e12_pulses"}, 32'({press_pulse, release_pulse}), 32'd0);
    chk({tag, "_press_cnt"}, 32'(press_seen - p0), lvl ? 32'd0 : 32'd1);
    chk({tag, "_release_cnt"}, 32'(release_seen - r0), lvl ? 32'd1 : 32'd0);
  endtask

  initial begin
    int p0;
    int r0;

    // Reset with the pin held low.
    reset_n = 1'b0;
    btn_in  = 1'b0;
`ifdef DEBOUNCE_STATS_EN
    stats_clr = 1'b0;
`endif
    step(3);
    chk("rst_out", 32'(btn_out), 32'd1);
    chk("rst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(STABLE_HI));
`ifdef DEBOUNCE_STATS_EN
    chk("rst_bounce", 32'(bounce_count), 32'd0);
`endif
    reset_n = 1'b1;
    settle(1'b0, "rst_rel");
    settle(1'b1, "rel1");

    // Clean press / release.
    settle(1'b0, "press");
    settle(1'b1, "release");

    // Glitch: 5 cycles low then high again.
`ifdef DEBOUNCE_STATS_EN
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    chk("clr_bounce", 32'(bounce_count), 32'd0);
`endif
    p0 = press_seen;
    r0 = release_seen;
    btn_in = 1'b0;
    step(5);
    btn_in = 1'b1;
    step(10);
    chk("glitch_out", 32'(btn_out), 32'd1);
    chk("glitch_state", 32'(dbg_state), 32'(STABLE_HI));
    chk("glitch_pulses", 32'((press_seen - p0) + (release_seen - r0)), 32'd0);
`ifdef DEBOUNCE_STATS_EN
    chk("glitch_bounce", 32'(bounce_count), 32'd1);
`endif

    // Bounce train: 4 x (3 low, 3 high), then held low.
`ifdef DEBOUNCE_STATS_EN
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
`endif
    p0 = press_seen;
    for (int i = 0; i < 4; i++) begin
      btn_in = 1'b0;
      step(3);
      btn_in = 1'b1;
      step(3);
    end
    btn_in = 1'b0;
    step(10);
    chk("train_e10_out", 32'(btn_out), 32'd1);
    step(1);
    chk("train_e11_out", 32'(btn_out), 32'd0);
    chk("train_e11_press", 32'(press_pulse), 32'd1);
    step(1);
    chk("train_press_cnt", 32'(press_seen - p0), 32'd1);
`ifdef DEBOUNCE_STATS_EN
    chk("train_bounce", 32'(bounce_count), 32'd4);
`endif
    settle(1'b1, "train_rel");

    // Reset in the middle of a pending press.
    p0 = press_seen;
    r0 = release_seen;
    btn_in = 1'b0;
    step(5);
    chk("midpend_state", 32'(dbg_state), 32'(PEND_LO));
    reset_n = 1'b0;
    step(1);
    chk("midrst_out", 32'(btn_out), 32'd1);
    chk("midrst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(STABLE_HI));
`ifdef DEBOUNCE_STATS_EN
    chk("midrst_bounce", 32'(bounce_count), 32'd0);
`endif
    reset_n = 1'b1;
    step(10);
    chk("restart_e10_out", 32'(btn_out), 32'd1);
    step(1);
    chk("restart_e11_out", 32'(btn_out), 32'd0);
    chk("restart_e11_press", 32'(press_pulse), 32'd1);
    step(1);
    chk("restart_press_cnt", 32'(press_seen - p0), 32'd1);
    chk("restart_release_cnt", 32'(release_seen - r0), 32'd0);
    settle(1'b1, "restart_rel");

`ifdef DEBOUNCE_STATS_EN
    // Saturation: preload all-ones, then one more glitch.
    force dut.bounce_q = 16'hFFFF;
    step(1);
    release dut.bounce_q;
    chk("sat_preload", 32'(bounce_count), 32'h0000_FFFF);
    btn_in = 1'b0;
    step(5);
    btn_in = 1'b1;
    step(10);
    chk("sat_hold", 32'(bounce_count), 32'h0000_FFFF);
    chk("sat_out", 32'(btn_out), 32'd1);

    // Clear on the very edge that aborts (third edge after returning high).
    btn_in = 1'b0;
    step(5);
    btn_in = 1'b1;
    step(2);
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    chk("clr_vs_abort", 32'(bounce_count), 32'd0);
    chk("clr_vs_abort_state", 32'(dbg_state), 32'(STABLE_HI));
    step(5);
    chk("clr_after", 32'(bounce_count), 32'd0);
    chk("clr_after_out", 32'(btn_out), 32'd1);
`endif

    chk("never_both_pulses", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
